frame_buffer_arbiter: RTL
=========================

Name: frame_buffer_arbiter

Overview:
- Shares one single-port 12-bit frame-buffer RAM between the VGA display read path and the camera capture write path.
- Display reads always win and have a fixed latency. Camera writes are absorbed by an internal write FIFO and drained into idle RAM cycles (blanking, porches).
- Sits between capture logic, the VGA display controller and the frame-buffer BRAM.

Parameters:
- RESOLUTION_WIDTH, 640, active pixels per line.
- RESOLUTION_HEIGHT, 480, active lines per frame.
- FIFO_DEPTH, 8, write FIFO entries; power of 2, minimum 2.
- Derived localparam AW = $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)+1, which is 20 at the defaults.

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  display read request; one pixel per cycle.
- rd_addr  in  AW  display read address.
- rd_data  out  12  RGB444 read data.
- rd_dv  out  1  rd_data valid.
- rd_frame_start  in  1  one-cycle pulse at the start of each display frame.
- wr_valid  in  1  capture pixel valid.
- wr_ready  out  1  FIFO can accept a pixel.
- wr_addr  in  AW  capture write address.
- wr_data  in  12  capture RGB444 pixel.
- wr_frame_end  in  1  one-cycle pulse after the last pixel of a captured frame.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW (AW+1 with DOUBLE_BUFFER_EN)  RAM address.
- mem_wdata  out  12  RAM write data.
- mem_rdata  in  12  RAM read data; 1-cycle RAM latency.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky drop flag.
- drop_count  out  16  saturating count of dropped pixels.
- clr_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset: while rst_n is low, every output is 0, wr_ready included. FIFO empties, overflow and drop_count clear, bank state resets.
- Port grant, evaluated each cycle N:
  - rd_req=1: read granted.
  - rd_req=0 and FIFO not empty: the FIFO head is popped and written.
  - Otherwise the RAM is idle.
  - Reads are never stalled or delayed by writes.
- RAM command: mem_en, mem_we, mem_addr and mem_wdata are registered and driven at N+1. During an idle cycle mem_en=0 and mem_we=0.
- Read latency: rd_data is registered from mem_rdata. rd_dv pulses exactly at N+3 for each rd_req at N.
  - Back-to-back requests give back-to-back rd_dv, in order.
  - rd_data holds its last value while rd_dv=0.
- FIFO contents: each entry stores {addr, data}, plus the bank bit when DOUBLE_BUFFER_EN is defined.
- Push: wr_valid && wr_ready. wr_ready = !full, combinational from registered state.
- No bypass: a pixel pushed into an empty FIFO is written no earlier than the next cycle.
- Simultaneous push and pop: level is unchanged. When full, the push is rejected regardless of a same-cycle pop.
- Drop on full: wr_valid=1 with wr_ready=0 drops the pixel, sets overflow=1 and increments drop_count, saturating at 0xFFFF. The camera cannot stall.
- clr_overflow:
  - Clears overflow and drop_count on the next edge.
  - If a drop happens in the same cycle, the flag ends set and the count ends at 1.
- Write ordering: FIFO order is preserved into RAM.
- Address range: no address range check; addresses pass through unchanged.

Optional Feature:
- Macro: DOUBLE_BUFFER_EN.
- When defined:
  - mem_addr is AW+1 bits wide; the MSB is the bank bit.
  - Registers wbank (reset 0) and rbank = ~wbank.
  - Pushed FIFO entries are tagged with the current wbank. Reads use rbank.
  - wr_frame_end sets swap_pending.
  - At rd_frame_start with swap_pending=1: wbank toggles, rbank toggles and swap_pending clears. There is no need to drain the FIFO, because entries carry their own bank.
  - wr_frame_end and rd_frame_start in the same cycle: the swap happens that cycle.
  - A second wr_frame_end before a swap has no extra effect.
- When undefined: mem_addr is AW bits, single bank, and frame pulses are ignored.

Test Plan:
- Reset, then rd_req=1 for 4 cycles at addrs 0..3 with RAM preloaded mem[i]=i+0x100 -> rd_dv high in cycles 3..6, rd_data 0x100..0x103; mem_we=0 throughout.
- rd_req=0, push 3 pixels (addr 10..12, data 0xA0A..0xA0C) -> mem_we pulses on 3 consecutive cycles starting 2 cycles after the first push, in order; fifo_level returns to 0.
- rd_req held 1 and 12 pixels pushed with FIFO_DEPTH=8 -> wr_ready drops after 8 accepted; 4 dropped; overflow=1, drop_count=4; after rd_req=0 the 8 entries are written; clr_overflow -> both 0.
- FIFO full, with push and drop in the same cycle as clr_overflow -> overflow=1, drop_count=1.
- DOUBLE_BUFFER_EN: write frame to bank 0, pulse wr_frame_end, then rd_frame_start -> subsequent reads have mem_addr MSB=0 and writes have MSB=1. rd_frame_start without a prior wr_frame_end -> no swap.
- Assert rst_n low mid-burst with FIFO level 5 -> outputs 0 immediately and fifo_level 0; after release, no stale write is issued.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares one single-port 12-bit frame-buffer RAM between
// the display read path (always wins, fixed 3-cycle latency) and the camera
// write path (buffered in a small FIFO, drained into idle RAM cycles).
// Optional feature macro: DOUBLE_BUFFER_EN (adds a bank bit on mem_addr and
// swaps display/capture banks at frame boundaries).
`default_nettype none

module frame_buffer_arbiter #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int FIFO_DEPTH        = 8,
  localparam int AW = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT) + 1,
`ifdef DOUBLE_BUFFER_EN
  localparam int MW = AW + 1,
`else
  localparam int MW = AW,
`endif
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [11:0]   rd_data,
  output logic          rd_dv,
  input  logic          rd_frame_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic          wr_frame_end,
  output logic          mem_en,
  output logic          mem_we,
  output logic [MW-1:0] mem_addr,
  output logic [11:0]   mem_wdata,
  input  logic [11:0]   mem_rdata,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic [15:0]   drop_count,
  input  logic          clr_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // FIFO entry layout: {bank (optional), address, pixel}; the RAM address is
  // the top MW bits so it can be forwarded to mem_addr unchanged.
  localparam int EW = MW + 12;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level;
  logic          empty, full;
  logic          push, pop, drop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic [MW-1:0] rd_cmd_addr;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [MW-1:0] mem_addr_q, mem_addr_d;
  logic [11:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0]    rd_pipe_q;
  logic          rd_dv_q;
  logic [11:0]   rd_data_q;

  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

`ifdef DOUBLE_BUFFER_EN
  logic          wbank_q, wbank_d;
  logic          swap_pending_q, swap_pending_d;

  assign push_entry  = {wbank_q, wr_addr, wr_data};
  assign rd_cmd_addr = {~wbank_q, rd_addr};

  // Bank swap bookkeeping: a finished capture frame is handed to the display
  // at the next display frame start (same-cycle pulses swap immediately).
  always_comb begin
    wbank_d        = wbank_q;
    swap_pending_d = swap_pending_q;
    if (rd_frame_start && (swap_pending_q || wr_frame_end)) begin
      wbank_d        = ~wbank_q;
      swap_pending_d = 1'b0;
    end else if (wr_frame_end) begin
      swap_pending_d = 1'b1;
    end
  end

  // Bank state registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q        <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      wbank_q        <= wbank_d;
      swap_pending_q <= swap_pending_d;
    end
  end
`else
  logic unused_frame_pulses;
  assign unused_frame_pulses = rd_frame_start ^ wr_frame_end;

  assign push_entry  = {wr_addr, wr_data};
  assign rd_cmd_addr = rd_addr;
`endif

  assign level      = wr_ptr_q - rd_ptr_q;
  assign empty      = (level == '0);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign head_entry = fifo_mem[rd_ptr_q[PW-1:0]];

  // Port grant: display read first, otherwise drain one FIFO entry.
  // A full FIFO rejects the push even if a pop frees a slot this cycle.
  always_comb begin
    pop      = !rd_req && !empty;
    push     = wr_valid && !full;
    drop     = wr_valid && full;
    wr_ptr_d = wr_ptr_q + LW'(push);
    rd_ptr_d = rd_ptr_q + LW'(pop);
  end

  // RAM command for the granted requester, registered onto the RAM port.
  always_comb begin
    mem_en_d    = rd_req || pop;
    mem_we_d    = pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_req) begin
      mem_addr_d = rd_cmd_addr;
    end else if (pop) begin
      mem_addr_d  = head_entry[EW-1:12];
      mem_wdata_d = head_entry[11:0];
    end
  end

  // Sticky drop flag and saturating drop counter; a drop in the clearing
  // cycle survives the clear.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clr_overflow) begin
      overflow_d   = drop;
      drop_count_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= push_entry;
    end
  end

  // FIFO pointers, RAM command and status registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Read return pipeline: command (N+1), RAM output (N+2), rd_data (N+3).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q <= '0;
      rd_dv_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_pipe_q <= {rd_pipe_q[0], rd_req};
      rd_dv_q   <= rd_pipe_q[1];
      if (rd_pipe_q[1]) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign wr_ready   = rst_n && !full;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_dv      = rd_dv_q;
  assign rd_data    = rd_data_q;
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

`default_nettype wire
